instr_mem_loader: RTL and testbench
===================================

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 11-bit instruction words held (address width 8).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port ld_start  input  1  request to begin a load session.
REQ-005 SHALL have port ld_valid  input  1  ld_byte carries a valid byte.
REQ-006 SHALL have port ld_ready  output  1  block accepts ld_byte this cycle.
REQ-007 SHALL have port ld_byte  input  8  load stream byte.
REQ-008 SHALL have port ld_done  output  1  one-cycle pulse when a session completes successfully.
REQ-009 SHALL have port ld_err  output  1  sticky format-error flag.
REQ-010 SHALL have port instr_addr  input  8  processor fetch address.
REQ-011 SHALL have port instr  output  11  instruction word to processor (opcode [10:8], operand address [7:0]).
REQ-012 SHALL have port cpu_rst  output  1  active-high reset driven to the processor.

Function
REQ-013 SHALL implement states HOLD, CNT, HI, LO, RUN.
REQ-014 SHALL transfer a byte only on a cycle with ld_valid=1 and ld_ready=1; ld_ready SHALL be 1 exactly in CNT, HI, LO.
REQ-015 SHALL, in HOLD or RUN with ld_start=1, enter CNT next cycle, clear ld_err and the write pointer to 0.
REQ-016 SHALL ignore ld_start in CNT, HI, LO.
REQ-017 SHALL, in CNT on transfer, latch remaining count N = ld_byte, 0 meaning 256, and enter HI.
REQ-018 SHALL, in HI on transfer with ld_byte[7:3]=0, latch ld_byte[2:0] as opcode and enter LO.
REQ-019 SHALL, in HI on transfer with ld_byte[7:3]!=0, set ld_err=1, write nothing, and enter HOLD.
REQ-020 SHALL, in LO on transfer, write {opcode, ld_byte} to word[pointer], increment pointer (8-bit wrap), decrement N.
REQ-021 SHALL, after the LO write that brings N to 0, enter RUN and assert ld_done for exactly that next cycle; otherwise return to HI.
REQ-022 SHALL leave words beyond the loaded count unchanged.
REQ-023 SHALL drive cpu_rst=1 in HOLD, CNT, HI, LO and cpu_rst=0 in RUN, registered (changes one cycle after the state transition decision, i.e. same cycle as new state).
REQ-024 SHALL drive instr = word[instr_addr] combinationally in RUN, and 11'b0 in all other states.
REQ-025 SHALL tolerate arbitrary ld_valid gaps; state and counters hold while no transfer occurs.
REQ-026 SHALL handle N=256: exactly 512 data bytes accepted, pointer wraps to 0 at completion.
REQ-027 SHALL accept ld_start in RUN to reload, reasserting cpu_rst from the CNT cycle onward.

Reset
REQ-028 SHALL, on rst=0 at a clock edge, enter HOLD with cpu_rst=1, ld_ready=0, ld_done=0, ld_err=0, pointer=0, N=0, opcode=0.
REQ-029 SHALL abort any session in progress on reset; partially written words remain, state is HOLD.
REQ-030 SHALL NOT clear word storage on reset; contents after power-up are undefined until loaded.
REQ-031 SHALL remain in HOLD after reset until a successful load; instr=0 throughout.

Verification
REQ-032 SHALL verify basic load: reset, ld_start, bytes 02,01,05,02,0A -> word0=0x105, word1=0x20A, ld_done pulse one cycle, cpu_rst 1->0, instr_addr=1 gives instr=0x20A.
REQ-033 SHALL verify format error: ld_start, bytes 01,F1 -> ld_err=1, state HOLD, cpu_rst=1, word0 unchanged, next ld_start clears ld_err.
REQ-034 SHALL verify N=0: count byte 00 then 512 data bytes with ld_valid toggling every other cycle -> all 256 words written, ld_done once, ld_ready=0 afterwards.
REQ-035 SHALL verify reload from RUN: running image, ld_start, count 01, bytes 03,FF -> cpu_rst=1 during session, word0=0x3FF, words 1..255 retain old image.
REQ-036 SHALL verify reset mid-session: rst=0 during LO -> HOLD, cpu_rst=1, ld_ready=0, ld_err=0, instr=0.
REQ-037 SHALL verify ld_start during HI is ignored: N and pointer unchanged, session completes normally.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-stream loader that fills instruction memory and holds the CPU in reset until done.
module instr_mem_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_start,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [7:0]  ld_byte,
    output logic        ld_done,
    output logic        ld_err,
    input  logic [7:0]  instr_addr,
    output logic [10:0] instr,
    output logic        cpu_rst
);
    typedef enum logic [2:0] {HOLD, CNT, HI, LO, RUN} state_t;
    state_t      state;
    logic [8:0]  cnt;
    logic [7:0]  ptr;
    logic [2:0]  op;
    logic [10:0] mem [DEPTH];
    logic        we;
    always_comb begin
        ld_ready = state == CNT || state == HI || state == LO;
        we       = rst && ld_valid && state == LO;
        instr    = state == RUN ? mem[instr_addr] : 11'd0;
    end
    // storage is deliberately never reset; a reset on the same edge suppresses the write
    always_ff @(posedge clk)
        if (we) mem[ptr] <= {op, ld_byte};
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= HOLD;
            cpu_rst <= 1'b1;
            ld_done <= 1'b0;
            ld_err  <= 1'b0;
            ptr     <= 8'd0;
            cnt     <= 9'd0;
            op      <= 3'd0;
        end else begin
            ld_done <= 1'b0;
            case (state)
                HOLD, RUN: if (ld_start) begin
                    state   <= CNT;
                    cpu_rst <= 1'b1;
                    ld_err  <= 1'b0;
                    ptr     <= 8'd0;
                end
                // a count byte of zero encodes 256 words
                CNT: if (ld_valid) begin
                    cnt   <= {ld_byte == 8'd0, ld_byte};
                    state <= HI;
                end
                HI: if (ld_valid) begin
                    if (ld_byte[7:3] == 5'd0) begin
                        op    <= ld_byte[2:0];
                        state <= LO;
                    end else begin
                        ld_err <= 1'b1;
                        state  <= HOLD;
                    end
                end
                LO: if (ld_valid) begin
                    ptr <= ptr + 8'd1;
                    cnt <= cnt - 9'd1;
                    if (cnt == 9'd1) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                        ld_done <= 1'b1;
                    end else begin
                        state <= HI;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed vector table plus hand sequences for error, 256-word, reload and reset cases.
module tb_instr_mem_loader;
    logic        clk = 1'b0;
    logic        rst, ld_start, ld_valid, ld_ready, ld_done, ld_err, cpu_rst;
    logic [7:0]  ld_byte, instr_addr;
    logic [10:0] instr;
    int          checks = 0, errors = 0, done_cnt = 0;
    logic        last_done;
    logic [10:0] exp_mem [256];

    typedef struct {
        logic        st, v;
        logic [7:0]  b, a;
        logic        rdy, dn, er, cr;
        logic [10:0] ins;
        string       nm;
    } vec_t;
    vec_t vq[$];

    instr_mem_loader dut (
        .clk(clk), .rst(rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_byte(ld_byte), .ld_done(ld_done), .ld_err(ld_err), .instr_addr(instr_addr),
        .instr(instr), .cpu_rst(cpu_rst)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [10:0] act, input logic [10:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic st, v, input logic [7:0] b, a,
                       input logic rdy, dn, er, cr, input logic [10:0] ins, input string nm);
        vq.push_back('{st, v, b, a, rdy, dn, er, cr, ins, nm});
    endtask

    // one transfer cycle followed by one idle cycle; records ld_done seen after the transfer
    task automatic send(input logic [7:0] b);
        ld_valid = 1'b1;
        ld_byte  = b;
        step();
        last_done = ld_done;
        if (ld_done) done_cnt++;
        ld_valid = 1'b0;
        ld_byte  = 8'hC3;
        step();
        if (ld_done) done_cnt++;
    endtask

    initial begin
        rst = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_byte = 8'h00; instr_addr = 8'h00;
        step();
        step();
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_ready", ld_ready, 0);
        chk("rst_done", ld_done, 0);
        chk("rst_err", ld_err, 0);
        chk("rst_instr", instr, 0);
        rst = 1'b1;
        step();
        chk("hold_instr", instr, 0);

        add(1, 0, 8'h00, 8'h00, 1, 0, 0, 1, 11'h000, "start");
        add(0, 1, 8'h02, 8'h00, 1, 0, 0, 1, 11'h000, "count");
        add(0, 0, 8'hEE, 8'h00, 1, 0, 0, 1, 11'h000, "gap");
        add(0, 1, 8'h01, 8'h00, 1, 0, 0, 1, 11'h000, "hi0");
        add(0, 1, 8'h05, 8'h00, 1, 0, 0, 1, 11'h000, "lo0");
        add(1, 0, 8'h00, 8'h00, 1, 0, 0, 1, 11'h000, "start_in_hi");
        add(0, 1, 8'h02, 8'h00, 1, 0, 0, 1, 11'h000, "hi1");
        add(0, 1, 8'h0A, 8'h01, 0, 1, 0, 0, 11'h20A, "lo1_done");
        add(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 11'h105, "run_w0");
        add(0, 0, 8'h00, 8'h01, 0, 0, 0, 0, 11'h20A, "run_w1");
        foreach (vq[i]) begin
            ld_start = vq[i].st; ld_valid = vq[i].v; ld_byte = vq[i].b; instr_addr = vq[i].a;
            step();
            chk({vq[i].nm, " ready"}, ld_ready, vq[i].rdy);
            chk({vq[i].nm, " done"}, ld_done, vq[i].dn);
            chk({vq[i].nm, " err"}, ld_err, vq[i].er);
            chk({vq[i].nm, " cpu_rst"}, cpu_rst, vq[i].cr);
            chk({vq[i].nm, " instr"}, instr, vq[i].ins);
        end
        ld_start = 1'b0; ld_valid = 1'b0; instr_addr = 8'h00;

        // format error: high byte with nonzero upper bits
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("fe_cpu_rst", cpu_rst, 1);
        send(8'h01);
        ld_valid = 1'b1; ld_byte = 8'hF1;
        step();
        chk("fe_err", ld_err, 1);
        chk("fe_ready", ld_ready, 0);
        chk("fe_cpu_rst_hold", cpu_rst, 1);
        chk("fe_instr", instr, 0);
        ld_byte = 8'h00;
        step();
        chk("fe_hold_ignores", ld_ready, 0);
        chk("fe_err_sticky", ld_err, 1);
        chk("fe_word0_kept", dut.mem[0], 11'h105);
        ld_valid = 1'b0; ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("fe_err_cleared", ld_err, 0);
        chk("fe_restart_ready", ld_ready, 1);

        // 256-word load with idle cycle between every byte
        done_cnt = 0;
        send(8'h00);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] idx;
            idx = 8'(i);
            exp_mem[i] = {idx[2:0], idx ^ 8'h5A};
            send({5'd0, idx[2:0]});
            chk("n0_no_early_done", {10'd0, last_done}, 0);
            send(idx ^ 8'h5A);
            if (i == 255) chk("n0_done_last", last_done, 1);
        end
        chk("n0_done_once", done_cnt, 1);
        chk("n0_ready_after", ld_ready, 0);
        chk("n0_cpu_rst", cpu_rst, 0);
        for (int i = 0; i < 256; i++) begin
            instr_addr = 8'(i);
            #1;
            chk($sformatf("n0_word%0d", i), instr, exp_mem[i]);
        end

        // reload a single word from RUN
        instr_addr = 8'h00;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        chk("rl_cpu_rst_cnt", cpu_rst, 1);
        chk("rl_ready", ld_ready, 1);
        chk("rl_instr", instr, 0);
        send(8'h01);
        send(8'h03);
        chk("rl_cpu_rst_lo", cpu_rst, 1);
        send(8'hFF);
        chk("rl_done", last_done, 1);
        chk("rl_cpu_rst_run", cpu_rst, 0);
        exp_mem[0] = 11'h3FF;
        for (int i = 0; i < 256; i++) begin
            instr_addr = 8'(i);
            #1;
            chk($sformatf("rl_word%0d", i), instr, exp_mem[i]);
        end

        // reset asserted while in LO
        instr_addr = 8'h00;
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
        send(8'h02);
        send(8'h01);
        rst = 1'b0; ld_valid = 1'b1; ld_byte = 8'h33;
        step();
        chk("mr_ready", ld_ready, 0);
        chk("mr_cpu_rst", cpu_rst, 1);
        chk("mr_err", ld_err, 0);
        chk("mr_done", ld_done, 0);
        chk("mr_instr", instr, 0);
        rst = 1'b1;
        step();
        chk("mr_hold_ready", ld_ready, 0);
        chk("mr_hold_cpu_rst", cpu_rst, 1);
        chk("mr_hold_instr", instr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
